// File: rtl/inst_loader.sv
// Boot-time program loader: unpacks a framed byte stream (length, big-endian words, XOR checksum)
// into 32-bit imem writes, holding the CPU in reset until a verified image is in place.
module inst_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wen,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0]           CAPACITY = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                r_state, w_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [15:0]           r_word_cnt;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_shift;
  logic [7:0]            r_xor;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_done;
  logic                  r_err;

  logic        w_xfer;
  logic        w_idle_like;
  logic        w_start;
  logic [15:0] w_len;
  logic        w_len_too_big;
  logic        w_last_byte;
  logic        w_last_word;

  assign w_xfer        = byte_valid & byte_ready;
  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_start       = start & w_idle_like;
  assign w_len         = {r_len_hi, byte_data};
  assign w_len_too_big = {1'b0, w_len} > CAPACITY;
  assign w_last_byte   = (r_byte_idx == 2'd3);
  assign w_last_word   = ((r_word_cnt + 16'd1) == r_len);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        cpu_hold = 1'b0;
        if (start) w_next = S_LEN_HI;
      end
      S_ERR: begin
        if (start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) begin
          if (w_len_too_big)       w_next = S_ERR;
          else if (w_len == 16'd0) w_next = S_CHECK;
          else                     w_next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        // The final word's write strobe lands in the first CHECK cycle.
        if (w_xfer && w_last_byte && w_last_word) w_next = S_CHECK;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer) w_next = (byte_data == r_xor) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_xor      <= '0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (w_start) begin
        r_len_hi   <= '0;
        r_len      <= '0;
        r_word_cnt <= '0;
        r_byte_idx <= '0;
        r_xor      <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end
      case (r_state)
        S_LEN_HI: if (w_xfer) r_len_hi <= byte_data;
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len_too_big) r_err <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_xor      <= r_xor ^ byte_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) begin
              r_wen      <= 1'b1;
              r_addr     <= BASE + r_word_cnt[ADDR_WIDTH-1:0];
              r_wdata    <= {r_shift, byte_data};
              r_word_cnt <= r_word_cnt + 16'd1;
            end else begin
              r_shift <= {r_shift[15:0], byte_data};
            end
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            if (byte_data == r_xor) r_done <= 1'b1;
            else                    r_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_wen   = r_wen;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: dut0 uses BASE_ADDR=0, dut1 uses BASE_ADDR=1020 for wrap-around.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [2];
  logic        bv      [2];
  logic [7:0]  bd      [2];
  logic        br      [2];
  logic        wen     [2];
  logic [9:0]  addr    [2];
  logic [31:0] wdata   [2];
  logic        hold    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];

  int checks = 0;
  int errors = 0;

  logic [41:0] q0[$];
  logic [41:0] q1[$];
  logic [31:0] wbuf[8];

  always #5 clk = ~clk;

  inst_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .byte_valid(bv[0]), .byte_data(bd[0]),
    .byte_ready(br[0]), .imem_wen(wen[0]), .imem_addr(addr[0]), .imem_wdata(wdata[0]),
    .cpu_hold(hold[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
  );

  inst_loader #(.ADDR_WIDTH(10), .BASE_ADDR(1020)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .byte_valid(bv[1]), .byte_data(bd[1]),
    .byte_ready(br[1]), .imem_wen(wen[1]), .imem_addr(addr[1]), .imem_wdata(wdata[1]),
    .cpu_hold(hold[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
  );

  // Write monitor: every imem_wen pops one expected {addr,data} from that DUT's queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k] === 1'b1) begin
        logic [41:0] e;
        logic        have;
        have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_write dut%0d: got addr=%h data=%h, expected no write", k, addr[k], wdata[k]);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if ({addr[k], wdata[k]} !== e) begin
            errors++;
            $display("FAIL imem_write dut%0d: got addr=%h data=%h, expected addr=%h data=%h",
                     k, addr[k], wdata[k], e[41:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Status vector: {byte_ready, cpu_hold, busy, done, err}
  task automatic status(input int k, input string name, input logic [4:0] exp);
    chk(name, {59'd0, br[k], hold[k], busy_s[k], done_s[k], err_s[k]}, {59'd0, exp});
  endtask

  task automatic push(input int k, input int a, input logic [31:0] d);
    logic [41:0] e;
    e = {10'(a % 1024), d};
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int t;
    t = 0;
    bv[k] = 1'b1;
    bd[k] = b;
    while (br[k] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: byte_ready stayed %b, expected 1", k, br[k]);
    end else begin
      @(negedge clk);
    end
    bv[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic send_words(input int k, input int n, input int base, input int gapmax, output logic [7:0] x);
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      push(k, base + i, wbuf[i]);
      for (int j = 0; j < 4; j++) begin
        b = wbuf[i][31 - 8*j -: 8];
        x = x ^ b;
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
        send(k, b);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      bv[k]      = 1'b0;
      bd[k]      = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    status(0, "reset_status", 5'b00000);
    chk("reset_imem", {wen[0], addr[0], wdata[0]}, 64'd0);

    // Single instruction; CHK = 24^08^00^05 = 29
    pulse_start(0);
    status(0, "t1_len_hi", 5'b11100);
    send(0, 8'h00); send(0, 8'h01);
    push(0, 0, 32'h24080005);
    send(0, 8'h24); send(0, 8'h08); send(0, 8'h00); send(0, 8'h05);
    status(0, "t1_before_chk", 5'b11100);
    send(0, 8'h29);
    status(0, "t1_done", 5'b00010);
    chk("t1_hold_addr_data", {addr[0], wdata[0]}, {22'd0, 10'd0, 32'h24080005});

    // Empty image: N=0, checksum 00
    pulse_start(0);
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    status(0, "t_empty_done", 5'b00010);

    // Length 1025 exceeds capacity
    pulse_start(0);
    status(0, "t3_start_clears_done", 5'b11100);
    send(0, 8'h04); send(0, 8'h01);
    status(0, "t3_len_err", 5'b01001);

    // Bad checksum (22 ^ 01), then recovery with a good frame
    pulse_start(0);
    wbuf[0] = 32'hDEADBEEF;
    send(0, 8'h00); send(0, 8'h01);
    send_words(0, 1, 0, 0, x);
    send(0, x ^ 8'h01);
    status(0, "t4_chk_err", 5'b01001);
    pulse_start(0);
    status(0, "t4_restart_clears_err", 5'b11100);
    send(0, 8'h00); send(0, 8'h01);
    send_words(0, 1, 0, 0, x);
    send(0, x);
    status(0, "t4_recovered", 5'b00010);

    // Random gaps with a start pulse in the middle of DATA
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788; wbuf[2] = 32'h99AABBCC;
    pulse_start(0);
    send(0, 8'h00); send(0, 8'h03);
    x = 8'h00;
    for (int i = 0; i < 3; i++) begin
      push(0, i, wbuf[i]);
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (i == 1 && j == 1) begin
          pulse_start(0);
          status(0, "t5_start_ignored", 5'b11100);
        end
        x = x ^ wbuf[i][31 - 8*j -: 8];
        send(0, wbuf[i][31 - 8*j -: 8]);
      end
    end
    send(0, x);
    status(0, "t5_done", 5'b00010);

    // Wrap-around on dut1: addresses 1020..1023, 0, 1
    for (int i = 0; i < 6; i++) wbuf[i] = {8'(i), 8'(i + 8'h10), 8'(i + 8'h20), 8'(i + 8'h30)} ^ 32'hA5C3_0F00;
    pulse_start(1);
    send(1, 8'h00); send(1, 8'h06);
    send_words(1, 6, 1020, 1, x);
    send(1, x);
    status(1, "t2_wrap_done", 5'b00010);

    // Reset after 2 of 4 bytes of word 3
    for (int i = 0; i < 5; i++) wbuf[i] = 32'h0BAD_0000 + 32'(i * 32'h0101);
    pulse_start(0);
    send(0, 8'h00); send(0, 8'h05);
    send_words(0, 3, 0, 0, x);
    send(0, wbuf[3][31:24]); send(0, wbuf[3][23:16]);
    status(0, "t6_mid_load", 5'b11100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    status(0, "t6_reset_status", 5'b00000);
    chk("t6_reset_imem", {wen[0], addr[0], wdata[0]}, 64'd0);

    repeat (4) @(negedge clk);
    chk("dut0_writes_drained", 64'(q0.size()), 64'd0);
    chk("dut1_writes_drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
